alu_mc: RTL and testbench

Multi-cycle, parametrised execute unit; next generation of the single-cycle RV32I ALU. Performs all RV32I integer ops with one-cycle registered latency, plus (optionally) RV32M multiply/divide via an iterative radix-2 datapath. Sits between decode/operand-read and writeback. Uses valid/ready handshakes on both sides so the pipeline can stall on long ops.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/alu_mdu_iter.sv | 88 ++++++++
 rtl/alu_mc.sv | 143 ++++++++++++++
 tb/tb_alu_mc.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu_mc execute unit: opcode encodings, FSM state
// encoding and the ZERO constant.
package alu_pkg;

    localparam logic [4:0] OP_ADD    = 5'b0_0000;
    localparam logic [4:0] OP_SUB    = 5'b0_1000;
    localparam logic [4:0] OP_SLL    = 5'b0_0001;
    localparam logic [4:0] OP_SLT    = 5'b0_0010;
    localparam logic [4:0] OP_SLTU   = 5'b0_0011;
    localparam logic [4:0] OP_XOR    = 5'b0_0100;
    localparam logic [4:0] OP_SRL    = 5'b0_0101;
    localparam logic [4:0] OP_SRA    = 5'b0_1101;
    localparam logic [4:0] OP_OR     = 5'b0_0110;
    localparam logic [4:0] OP_AND    = 5'b0_0111;

    localparam logic [4:0] OP_MUL    = 5'b1_0000;
    localparam logic [4:0] OP_MULH   = 5'b1_0001;
    localparam logic [4:0] OP_MULHSU = 5'b1_0010;
    localparam logic [4:0] OP_MULHU  = 5'b1_0011;
    localparam logic [4:0] OP_DIV    = 5'b1_0100;
    localparam logic [4:0] OP_DIVU   = 5'b1_0101;
    localparam logic [4:0] OP_REM    = 5'b1_0110;
    localparam logic [4:0] OP_REMU   = 5'b1_0111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    // Wide enough for the largest supported XLEN; users slice it down.
    localparam int MAX_XLEN = 64;
    localparam logic [MAX_XLEN-1:0] ZERO = '0;

endpackage

// File: rtl/alu_mdu_iter.sv
// Iterative radix-2 multiply (shift-add) / divide (restoring) datapath over
// operand magnitudes, with the signed fix-up applied on the result output.
module alu_mdu_iter
    import alu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN) + 1;

    logic              busy, div_q, neg_q, rneg_q;
    logic [1:0]        sel_q;
    logic [CW-1:0]     cnt;
    logic [2*XLEN-1:0] acc, acc_src, acc_nxt, prod;
    logic [XLEN-1:0]   opb_q, opb, mag_a, mag_b, quo, rem;
    logic              a_signed, b_signed, neg_a, neg_b, div_mode, ge;
    logic [XLEN:0]     shifted, diff, msum;

    assign a_signed = op[2] ? !op[0] : (op[1:0] != 2'b11);
    assign b_signed = op[2] ? !op[0] : !op[1];
    assign neg_a    = a_signed && a[XLEN-1];
    assign neg_b    = b_signed && b[XLEN-1];
    assign mag_a    = neg_a ? -a : a;
    assign mag_b    = neg_b ? -b : b;

    // The first step is taken on the start edge itself, straight from the operands.
    assign acc_src  = start ? {ZERO[XLEN-1:0], mag_a} : acc;
    assign opb      = start ? mag_b : opb_q;
    assign div_mode = start ? op[2] : div_q;

    assign shifted  = {acc_src[2*XLEN-1:XLEN], acc_src[XLEN-1]};
    assign diff     = shifted - {1'b0, opb};
    assign ge       = !diff[XLEN];
    assign msum     = {1'b0, acc_src[2*XLEN-1:XLEN]} + {1'b0, (acc_src[0] ? opb : ZERO[XLEN-1:0])};
    assign acc_nxt  = div_mode ? {(ge ? diff[XLEN-1:0] : shifted[XLEN-1:0]), acc_src[XLEN-2:0], ge}
                               : {msum, acc_src[XLEN-1:1]};

    assign done   = busy && (cnt == CW'(XLEN));
    assign prod   = neg_q ? -acc : acc;
    assign quo    = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
    assign rem    = rneg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
    assign result = div_q ? (sel_q[1] ? rem : quo)
                          : ((sel_q == 2'b00) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            opb_q  <= '0;
            div_q  <= 1'b0;
            neg_q  <= 1'b0;
            rneg_q <= 1'b0;
            sel_q  <= 2'b00;
        end else if (flush) begin
            busy <= 1'b0;
            cnt  <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= CW'(1);
            acc    <= acc_nxt;
            opb_q  <= mag_b;
            div_q  <= op[2];
            neg_q  <= neg_a ^ neg_b;
            rneg_q <= neg_a;
            sel_q  <= op[1:0];
        end else if (busy) begin
            if (done) begin
                busy <= 1'b0;
                cnt  <= '0;
            end else begin
                acc <= acc_nxt;
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle RV32I/RV32M execute unit with valid/ready on both sides.
// Define ALU_MDU_EN to compile in the iterative multiply/divide unit.
module alu_mc
    import alu_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      alu_op,
    input  logic [XLEN-1:0] in1,
    input  logic [XLEN-1:0] in2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out,
    output logic            zero,
    output logic            overflow,
    output logic            invalid_op
);

    state_t          state;
    logic            accept, is_sub, ovf, inv;
    logic [XLEN-1:0] opb, sum, res;
    logic [SHW-1:0]  shamt;
`ifdef ALU_MDU_EN
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};
    logic            go_mul, go_div, mdu_done;
    logic [XLEN-1:0] mdu_result;
`endif

    assign in_ready = (state == IDLE) || (state == DONE && out_ready);
    assign accept   = in_valid && in_ready && !flush;
    assign shamt    = in2[SHW-1:0];
    assign is_sub   = (alu_op == OP_SUB);
    assign opb      = is_sub ? ~in2 : in2;
    assign sum      = in1 + opb + {{(XLEN-1){1'b0}}, is_sub};

    // Single-cycle result; DIV/REM corner cases resolve here without iterating.
    always_comb begin
        res = ZERO[XLEN-1:0];
        ovf = 1'b0;
        inv = 1'b0;
`ifdef ALU_MDU_EN
        go_mul = 1'b0;
        go_div = 1'b0;
`endif
        case (alu_op)
            OP_ADD, OP_SUB: begin
                res = sum;
                ovf = (in1[XLEN-1] == opb[XLEN-1]) && (sum[XLEN-1] != in1[XLEN-1]);
            end
            OP_SLL:  res = in1 << shamt;
            OP_SLT:  res = {{(XLEN-1){1'b0}}, $signed(in1) < $signed(in2)};
            OP_SLTU: res = {{(XLEN-1){1'b0}}, in1 < in2};
            OP_XOR:  res = in1 ^ in2;
            OP_SRL:  res = in1 >> shamt;
            OP_SRA:  res = $unsigned($signed(in1) >>> shamt);
            OP_OR:   res = in1 | in2;
            OP_AND:  res = in1 & in2;
`ifdef ALU_MDU_EN
            OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU: go_mul = 1'b1;
            OP_DIV, OP_DIVU, OP_REM, OP_REMU: begin
                if (in2 == ZERO[XLEN-1:0])
                    res = alu_op[1] ? in1 : ~ZERO[XLEN-1:0];
                else if (!alu_op[0] && in1 == MOST_NEG && in2 == ~ZERO[XLEN-1:0])
                    res = alu_op[1] ? ZERO[XLEN-1:0] : in1;
                else
                    go_div = 1'b1;
            end
`endif
            default: inv = 1'b1;
        endcase
    end

`ifdef ALU_MDU_EN
    alu_mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst_n  (rst_n),
        .flush  (flush),
        .start  (accept && (go_mul || go_div)),
        .op     (alu_op[2:0]),
        .a      (in1),
        .b      (in2),
        .done   (mdu_done),
        .result (mdu_result)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out        <= ZERO[XLEN-1:0];
            zero       <= 1'b0;
            overflow   <= 1'b0;
            invalid_op <= 1'b0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out        <= res;
                        zero       <= (res == ZERO[XLEN-1:0]);
                        overflow   <= ovf;
                        invalid_op <= inv;
`ifdef ALU_MDU_EN
                        // Long ops override the registered result until the datapath finishes.
                        if (go_mul || go_div) begin
                            state     <= go_mul ? MUL : DIV;
                            out_valid <= 1'b0;
                        end
`endif
                    end else if (state == DONE && out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
`ifdef ALU_MDU_EN
                MUL, DIV: begin
                    if (mdu_done) begin
                        state      <= DONE;
                        out_valid  <= 1'b1;
                        out        <= mdu_result;
                        zero       <= (mdu_result == ZERO[XLEN-1:0]);
                        overflow   <= 1'b0;
                        invalid_op <= 1'b0;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard testbench for alu_mc (XLEN=32); exercises the multiply/divide
// paths when ALU_MDU_EN is defined, otherwise checks that m=1 opcodes are invalid.
module tb_alu_mc;
    import alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic        zero, overflow, invalid_op;
    logic [4:0]  alu_op;
    logic [31:0] in1, in2, out;

    int n_checks = 0;
    int n_fail   = 0;
    int cycle    = 0;

    typedef struct {
        logic [31:0] res;
        logic        zf;
        logic        of;
        logic        iv;
        int          due;
        string       name;
    } exp_t;

    exp_t sb[$];

    alu_mc #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_op     (alu_op),
        .in1        (in1),
        .in2        (in2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out        (out),
        .zero       (zero),
        .overflow   (overflow),
        .invalid_op (invalid_op)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Present one request, wait for acceptance, and optionally queue its expected result.
    // lat counts edges from the accept edge: 1 for single-cycle, 33 for iterative ops.
    task automatic applyStimulus(input string name, input logic [4:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] eres, input logic eof, input logic eiv,
                                 input int lat, input bit push);
        int   budget = 100;
        exp_t e;
        alu_op   = op;
        in1      = a;
        in2      = b;
        in_valid = 1'b1;
        while (!in_ready && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (!in_ready) begin
            checkOutput({name, "_accept_timeout"}, 32'(in_ready), 32'd1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (push) begin
            e.res  = eres;
            e.zf   = (eres == 32'd0);
            e.of   = eof;
            e.iv   = eiv;
            e.due  = cycle + lat - 1;
            e.name = name;
            sb.push_back(e);
        end
    endtask

    task automatic waitDrain();
        int budget = 200;
        while (sb.size() != 0 && budget > 0) begin
            @(posedge clk); #1;
            budget--;
        end
        if (sb.size() != 0) begin
            checkOutput("drain_timeout", 32'(sb.size()), 32'd0);
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Monitor: every accepted output handshake is matched against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                e = sb.pop_front();
                checkOutput({e.name, "_out"}, out, e.res);
                checkOutput({e.name, "_zero"}, 32'(zero), 32'(e.zf));
                checkOutput({e.name, "_overflow"}, 32'(overflow), 32'(e.of));
                checkOutput({e.name, "_invalid"}, 32'(invalid_op), 32'(e.iv));
                checkOutput({e.name, "_cycle"}, 32'(cycle), 32'(e.due));
            end
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int stable_bad;
        int ready_bad;
        int seen_valid;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        alu_op    = 5'd0;
        in1       = 32'd0;
        in2       = 32'd0;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset_out", out, 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd0);
        checkOutput("reset_overflow", 32'(overflow), 32'd0);
        checkOutput("reset_invalid", 32'(invalid_op), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops, one result per cycle.
        applyStimulus("add_ovf",  OP_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0, 1, 1'b1);
        applyStimulus("sub_zero", OP_SUB,  32'h0000_0005, 32'h0000_0005, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("sra",      OP_SRA,  32'h8000_0000, 32'h0000_0021, 32'hC000_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("sltu",     OP_SLTU, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("slt",      OP_SLT,  32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("sub_ovf",  OP_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 1'b1, 1'b0, 1, 1'b1);
        applyStimulus("add_wrap", OP_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("sll",      OP_SLL,  32'h0000_0001, 32'h0000_003F, 32'h8000_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("srl",      OP_SRL,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("xor",      OP_XOR,  32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'hFF00_FF00, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("or",       OP_OR,   32'h1200_0034, 32'h0034_1200, 32'h1234_1234, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("and",      OP_AND,  32'hFFFF_0000, 32'h0F0F_0F0F, 32'h0F0F_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("undef_09", 5'b0_1001, 32'h1234_5678, 32'h1, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b1);
        waitDrain();

`ifdef ALU_MDU_EN
        applyStimulus("mulh", OP_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 33, 1'b1);
        ready_bad = 0;
        for (int k = 0; k < 32; k++) begin
            if (in_ready) ready_bad++;
            if (k < 31) begin
                @(posedge clk); #1;
            end
        end
        checkOutput("mul_in_ready_low", 32'(ready_bad), 32'd0);
        waitDrain();
        applyStimulus("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0, 33, 1'b1);
        waitDrain();
        applyStimulus("mul",    OP_MUL,    32'h0000_0003, 32'hFFFF_FFFC, 32'hFFFF_FFF4, 1'b0, 1'b0, 33, 1'b1);
        waitDrain();
        applyStimulus("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 1'b1);
        waitDrain();
        applyStimulus("div",    OP_DIV,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFD, 1'b0, 1'b0, 33, 1'b1);
        waitDrain();
        applyStimulus("rem",    OP_REM,    32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 1'b0, 1'b0, 33, 1'b1);
        waitDrain();
        applyStimulus("divu",   OP_DIVU,   32'h0000_0064, 32'h0000_0007, 32'h0000_000E, 1'b0, 1'b0, 33, 1'b1);
        waitDrain();
        applyStimulus("remu",   OP_REMU,   32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 1'b0, 1'b0, 33, 1'b1);
        waitDrain();
        applyStimulus("divu_by0", OP_DIVU, 32'h0000_0005, 32'h0000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("remu_by0", OP_REMU, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("div_ovf",  OP_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("rem_ovf",  OP_REM,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1'b0, 1, 1'b1);
        applyStimulus("undef_18", 5'b1_1000, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b1);
        waitDrain();
`else
        applyStimulus("mul_undef", 5'b1_0000, 32'h0000_0003, 32'h0000_0004, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b1);
        applyStimulus("div_undef", 5'b1_0100, 32'h0000_0009, 32'h0000_0003, 32'h0000_0000, 1'b0, 1'b1, 1, 1'b1);
        waitDrain();
`endif

        // Stall: result must hold while the consumer is not ready.
        out_ready = 1'b0;
        applyStimulus("stall_add", OP_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0000_0007, 1'b0, 1'b0, 1, 1'b0);
        stable_bad = 0;
        ready_bad  = 0;
        for (int k = 0; k < 10; k++) begin
            if (!out_valid || out !== 32'h0000_0007) stable_bad++;
            if (in_ready) ready_bad++;
            @(posedge clk); #1;
        end
        checkOutput("stall_out_stable", 32'(stable_bad), 32'd0);
        checkOutput("stall_in_ready_low", 32'(ready_bad), 32'd0);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        checkOutput("flush_out_valid", 32'(out_valid), 32'd0);
        checkOutput("flush_in_ready", 32'(in_ready), 32'd1);

        // Flush in the same cycle as a valid request: the request is dropped.
        alu_op   = OP_ADD;
        in1      = 32'h0000_0001;
        in2      = 32'h0000_0001;
        in_valid = 1'b1;
        flush    = 1'b1;
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        checkOutput("flush_blocks_accept", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        checkOutput("flush_no_late_result", 32'(out_valid), 32'd0);
        out_ready = 1'b1;

        // Asynchronous reset in the middle of an operation.
`ifdef ALU_MDU_EN
        applyStimulus("div_rst", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002, 32'h0, 1'b0, 1'b0, 33, 1'b0);
        repeat (9) @(posedge clk);
        #2;
`else
        out_ready = 1'b0;
        applyStimulus("add_rst", OP_ADD, 32'h0000_0003, 32'h0000_0004, 32'h0, 1'b0, 1'b0, 1, 1'b0);
        #2;
`endif
        rst_n = 1'b0;
        #1;
        checkOutput("async_rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("async_rst_out", out, 32'd0);
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen_valid = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen_valid++;
        end
        checkOutput("no_result_after_reset", 32'(seen_valid), 32'd0);

        applyStimulus("post_rst_xor", OP_XOR, 32'hAAAA_5555, 32'hFFFF_FFFF, 32'h5555_AAAA, 1'b0, 1'b0, 1, 1'b1);
        waitDrain();
        checkOutput("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
